tag_responder_iter: RTL and testbench

- Downstream consumer of the tag register in the CAPP array.
- Snapshots the num_cells-wide tag vector on request, then delivers the index of every set tag, lowest index first, one per handshake on a valid/ready stream.
- Used by the sequencer/readout path to visit each responder in turn (multiple-response resolution) without re-running the compare.

---
 rtl/tag_responder_iter.sv | 111 +++++++++++
 tb/tb_tag_responder_iter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tag_responder_iter.sv
// tag_responder_iter: snapshots the CAPP tag vector on load and walks every set
// tag lowest-index-first, one index per valid/ready handshake.
// Latency: first index visible 1 cycle after the load edge; one index per cycle
//   with rsp_ready held high.
// Backpressure: rsp_index/rsp_valid hold while rsp_ready is low.
// Ports:
//   CLK, RST        clock, async active-high reset
//   tags_in, load   tag vector and capture strobe (honoured only when idle)
//   abort           drop remaining responders, return to idle (no done pulse)
//   busy, any_resp  iterating / captured vector had at least one responder
//   rsp_valid, rsp_ready, rsp_index  responder index stream
//   rsp_count       responses accepted since the last load
//   done            one-cycle completion pulse (all delivered or empty load)
module tag_responder_iter #(
  parameter int num_cells = 100,
  parameter int idx_bits  = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [num_cells-1:0] tags_in,
  input  logic                 load,
  input  logic                 abort,
  output logic                 busy,
  output logic                 any_resp,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [idx_bits-1:0]  rsp_index,
  output logic [idx_bits:0]    rsp_count,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [num_cells-1:0]  pending, pending_nxt;
  logic [idx_bits-1:0]   rsp_index_nxt;
  logic                  rsp_valid_nxt;
  logic [idx_bits:0]     rsp_count_nxt;
  logic                  any_resp_nxt;
  logic                  done_nxt;
  logic                  hs;
  logic                  load_ok;

  // Lowest-set-bit priority encoder; scanning downward lets the lowest hit win.
  function automatic logic [idx_bits-1:0] lowest_set(input logic [num_cells-1:0] v);
    lowest_set = '0;
    for (int i = num_cells - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = idx_bits'(i);
    end
  endfunction

  assign hs      = (state == RUN) && rsp_valid && rsp_ready;
  assign load_ok = (state == IDLE) && load;

  // State register plus the registered datapath/outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      pending   <= '0;
      rsp_valid <= 1'b0;
      rsp_index <= '0;
      rsp_count <= '0;
      any_resp  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_index <= rsp_index_nxt;
      rsp_count <= rsp_count_nxt;
      any_resp  <= any_resp_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-datapath logic. abort outranks load and handshake.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    rsp_count_nxt = rsp_count;
    any_resp_nxt  = any_resp;
    done_nxt      = 1'b0;
    if (abort) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
    end else if (load_ok) begin
      pending_nxt   = tags_in;
      rsp_count_nxt = '0;
      any_resp_nxt  = |tags_in;
      if (|tags_in) state_nxt = RUN;
      else          done_nxt  = 1'b1;
    end else if (hs) begin
      pending_nxt   = pending & ~({{(num_cells-1){1'b0}}, 1'b1} << rsp_index);
      rsp_count_nxt = rsp_count + 1'b1;
      if (pending_nxt == '0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end
    // Valid/index follow the next pending value, so they only move on a
    // load, handshake or abort and stay stable under backpressure.
    rsp_valid_nxt = |pending_nxt;
    rsp_index_nxt = lowest_set(pending_nxt);
  end

  // Output decode.
  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_tag_responder_iter.sv
module tb_tag_responder_iter;

  localparam int NC = 8;
  localparam int IB = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NC-1:0] tags_in;
  logic          load;
  logic          abort;
  logic          busy;
  logic          any_resp;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IB-1:0] rsp_index;
  logic [IB:0]   rsp_count;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  tag_responder_iter #(.num_cells(NC), .idx_bits(IB)) dut (
    .CLK(CLK), .RST(RST), .tags_in(tags_in), .load(load), .abort(abort),
    .busy(busy), .any_resp(any_resp), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_index(rsp_index), .rsp_count(rsp_count),
    .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check every output at once: valid, index, count, busy, any_resp, done.
  task automatic chk_all(input string tag, input logic v, input logic [IB-1:0] idx,
                         input logic [IB:0] cnt, input logic b, input logic a,
                         input logic d);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    if (v) chk({tag, ".index"}, 32'(rsp_index), 32'(idx));
    chk({tag, ".count"}, 32'(rsp_count), 32'(cnt));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".any"},   32'(any_resp),  32'(a));
    chk({tag, ".done"},  32'(done),      32'(d));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; tags_in = '0; load = 1'b0; abort = 1'b0; rsp_ready = 1'b0;
    #12;
    chk_all("reset", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.index", 32'(rsp_index), 32'd0);
    RST = 1'b0;
    tick();

    // 1: 1010_0100 with rsp_ready high -> 2,5,7 back to back, then done.
    tags_in = 8'b1010_0100; load = 1'b1; rsp_ready = 1'b1;
    tick(); load = 1'b0; tags_in = 8'hFF;  // later tags_in changes are ignored
    chk_all("t1.c0", 1'b1, 3'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t1.c1", 1'b1, 3'd5, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t1.c2", 1'b1, 3'd7, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t1.done", 1'b0, 3'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("t1.post", 1'b0, 3'd0, 4'd3, 1'b0, 1'b1, 1'b0);

    // 2: empty load -> immediate done, never valid.
    tags_in = 8'b0000_0000; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("t2.done", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("t2.post", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // 3: 1000_0001 with a 5-cycle stall -> index 0 held, then 7, then done.
    tags_in = 8'b1000_0001; load = 1'b1; rsp_ready = 1'b0;
    tick(); load = 1'b0;
    chk_all("t3.c0", 1'b1, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("t3.stall", 1'b1, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    end
    rsp_ready = 1'b1;
    tick(); chk_all("t3.c1", 1'b1, 3'd7, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t3.done", 1'b0, 3'd0, 4'd2, 1'b0, 1'b1, 1'b1);

    // 4: all ones, accept 3, abort -> idle, count kept, no done.
    tags_in = 8'b1111_1111; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("t4.c0", 1'b1, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t4.c1", 1'b1, 3'd1, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t4.c2", 1'b1, 3'd2, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t4.c3", 1'b1, 3'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;  // handshake also present; abort wins
    tick(); abort = 1'b0;
    chk_all("t4.abort", 1'b0, 3'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("t4.idle", 1'b0, 3'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    tags_in = 8'b0001_0000; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("t4.reload", 1'b1, 3'd4, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t4.done", 1'b0, 3'd0, 4'd1, 1'b0, 1'b1, 1'b1);

    // 5: load during RUN is ignored.
    tags_in = 8'b1010_0100; load = 1'b1;
    tick();
    chk_all("t5.c0", 1'b1, 3'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    tags_in = 8'b0000_0010;  // load still high while running
    tick(); load = 1'b0;
    chk_all("t5.c1", 1'b1, 3'd5, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t5.c2", 1'b1, 3'd7, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t5.done", 1'b0, 3'd0, 4'd3, 1'b0, 1'b1, 1'b1);

    // 6: asynchronous reset mid-RUN.
    tags_in = 8'b1111_1111; load = 1'b1; rsp_ready = 1'b0;
    tick(); load = 1'b0;
    chk_all("t6.run", 1'b1, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    #3 RST = 1'b1;
    #1 chk_all("t6.arst", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("t6.arst.index", 32'(rsp_index), 32'd0);
    @(negedge CLK); RST = 1'b0; rsp_ready = 1'b1;
    tick(); chk_all("t6.post", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tags_in = 8'b0000_0100; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("t6.reload", 1'b1, 3'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("t6.done", 1'b0, 3'd0, 4'd1, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
